// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared encodings for the washing-machine plant responder
package wm_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_HEAT  = 3'd2,
    ST_ARMED = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    PH_NONE  = 3'd0,
    PH_SOAK  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_t;

  // Command vector bit order: {spin, rinse, wash, soak}.
  function automatic logic [2:0] cmd_count(input logic [3:0] cmds);
    return 3'(cmds[0]) + 3'(cmds[1]) + 3'(cmds[2]) + 3'(cmds[3]);
  endfunction

  function automatic phase_t phase_of(input logic [3:0] cmds);
    case (cmds)
      4'b0001: return PH_SOAK;
      4'b0010: return PH_WASH;
      4'b0100: return PH_RINSE;
      4'b1000: return PH_SPIN;
      default: return PH_NONE;
    endcase
  endfunction

  function automatic logic cmd_of(input phase_t p, input logic [3:0] cmds);
    case (p)
      PH_SOAK:  return cmds[0];
      PH_WASH:  return cmds[1];
      PH_RINSE: return cmds[2];
      PH_SPIN:  return cmds[3];
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wm_down_counter.sv
// rtl/wm_down_counter.sv - loadable down counter that saturates at zero
module wm_down_counter
  import wm_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  cnt_t i_load_val,
  input  logic i_en,
  output logic o_zero
);

  cnt_t r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/wm_plant_responder.sv
// rtl/wm_plant_responder.sv - plant-side responder sequencing fill, heat and timed phases
module wm_plant_responder
  import wm_pkg::*;
#(
  parameter int unsigned FILL_CYCLES  = 8,
  parameter int unsigned HEAT_CYCLES  = 6,
  parameter int unsigned SOAK_CYCLES  = 10,
  parameter int unsigned WASH_CYCLES  = 12,
  parameter int unsigned RINSE_CYCLES = 8,
  parameter int unsigned SPIN_CYCLES  = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       water_Intake,
  input  logic       soak_Operation,
  input  logic       wash_Operation,
  input  logic       rinse_Operation,
  input  logic       spin_Operation,
  input  logic       lid,
  input  logic       cancel,
  output logic       fill_Water,
  output logic       heat_Water,
  output logic       wash,
  output logic       plant_Error,
  output logic       busy,
  output logic [2:0] phase
);

  localparam cnt_t FILL_LD  = cnt_t'(FILL_CYCLES - 1);
  localparam cnt_t HEAT_LD  = cnt_t'(HEAT_CYCLES - 1);
  localparam cnt_t SOAK_LD  = cnt_t'(SOAK_CYCLES - 1);
  localparam cnt_t WASH_LD  = cnt_t'(WASH_CYCLES - 1);
  localparam cnt_t RINSE_LD = cnt_t'(RINSE_CYCLES - 1);
  localparam cnt_t SPIN_LD  = cnt_t'(SPIN_CYCLES - 1);

  state_t r_state, w_state_n;
  phase_t r_phase, w_phase_n;
  logic   r_fill, r_heat, r_wash, r_err, r_busy;
  logic   w_fill_n, w_heat_n, w_wash_n, w_err_n, w_busy_n;
  logic   w_load, w_en, w_zero;
  cnt_t   w_load_val;
  logic [3:0] w_cmds;
  logic [2:0] w_ncmd;

  assign w_cmds = {spin_Operation, rinse_Operation, wash_Operation, soak_Operation};
  assign w_ncmd = cmd_count(w_cmds);

  wm_down_counter u_cnt (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    w_fill_n   = r_fill;
    w_heat_n   = r_heat;
    w_wash_n   = 1'b0;
    w_err_n    = r_err;
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b0;

    if (cancel) begin
      w_state_n = ST_IDLE;
      w_phase_n = PH_NONE;
      w_fill_n  = 1'b0;
      w_heat_n  = 1'b0;
      w_err_n   = 1'b0;
      w_load    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (water_Intake) begin
          w_state_n  = ST_FILL;
          w_load     = 1'b1;
          w_load_val = FILL_LD;
        end
        ST_FILL: if (!lid) begin
          if (!water_Intake) begin
            w_state_n = ST_IDLE;
            w_load    = 1'b1;
          end else if (w_zero) begin
            w_state_n  = ST_HEAT;
            w_fill_n   = 1'b1;
            w_load     = 1'b1;
            w_load_val = HEAT_LD;
          end else begin
            w_en = 1'b1;
          end
        end
        ST_HEAT: if (!lid) begin
          if (w_zero) begin
            w_state_n = ST_ARMED;
            w_heat_n  = 1'b1;
          end else begin
            w_en = 1'b1;
          end
        end
        ST_ARMED: if (w_ncmd == 3'd1) begin
          w_state_n = ST_RUN;
          w_phase_n = phase_of(w_cmds);
          w_load    = 1'b1;
          case (phase_of(w_cmds))
            PH_SOAK:  w_load_val = SOAK_LD;
            PH_WASH:  w_load_val = WASH_LD;
            PH_RINSE: w_load_val = RINSE_LD;
            default:  w_load_val = SPIN_LD;
          endcase
        end else if (w_ncmd > 3'd1) begin
          w_state_n = ST_HALT;
        end
        // A frozen lid holds the run exactly, including command checks.
        ST_RUN: if (!lid) begin
          if (!cmd_of(r_phase, w_cmds)) begin
            w_state_n = ST_ARMED;
            w_phase_n = PH_NONE;
          end else if (w_ncmd > 3'd1) begin
            w_state_n = ST_HALT;
          end else if (w_zero) begin
            w_state_n = ST_DONE;
            w_wash_n  = 1'b1;
          end else begin
            w_en = 1'b1;
          end
        end
        ST_DONE: if (w_ncmd == 3'd0) begin
          w_phase_n = PH_NONE;
          if (r_phase == PH_SPIN) begin
            w_state_n = ST_IDLE;
            w_fill_n  = 1'b0;
            w_heat_n  = 1'b0;
          end else begin
            w_state_n = ST_ARMED;
          end
        end
        ST_HALT: ;
        default: w_state_n = ST_IDLE;
      endcase

      if (w_state_n == ST_HALT) begin
        w_phase_n = PH_NONE;
        w_fill_n  = 1'b0;
        w_heat_n  = 1'b0;
        w_err_n   = 1'b1;
      end
    end

    w_busy_n = (w_state_n == ST_FILL) || (w_state_n == ST_HEAT) || (w_state_n == ST_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= PH_NONE;
      r_fill  <= 1'b0;
      r_heat  <= 1'b0;
      r_wash  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_phase <= w_phase_n;
      r_fill  <= w_fill_n;
      r_heat  <= w_heat_n;
      r_wash  <= w_wash_n;
      r_err   <= w_err_n;
      r_busy  <= w_busy_n;
    end
  end

  assign fill_Water  = r_fill;
  assign heat_Water  = r_heat;
  assign wash        = r_wash;
  assign plant_Error = r_err;
  assign busy        = r_busy;
  assign phase       = r_phase;

endmodule

// File: tb/tb_wm_plant_responder.sv
// tb/tb_wm_plant_responder.sv - directed scoreboard bench for wm_plant_responder
module tb_wm_plant_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic water_Intake = 1'b0;
  logic soak_Operation = 1'b0, wash_Operation = 1'b0, rinse_Operation = 1'b0, spin_Operation = 1'b0;
  logic lid = 1'b0, cancel = 1'b0;
  logic fill_Water, heat_Water, wash, plant_Error, busy;
  logic [2:0] phase;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  int lid_steps;

  // Packed output view: {fill, heat, wash, err, busy, phase[2:0]}
  localparam int O_FILL = 8'h80, O_HEAT = 8'h40, O_WASH = 8'h20, O_ERR = 8'h10, O_BUSY = 8'h08;

  always #5 clock = ~clock;

  wm_plant_responder #(
    .FILL_CYCLES(4), .HEAT_CYCLES(3), .SOAK_CYCLES(10),
    .WASH_CYCLES(5), .RINSE_CYCLES(3), .SPIN_CYCLES(5)
  ) dut (
    .clock(clock), .reset(reset), .water_Intake(water_Intake),
    .soak_Operation(soak_Operation), .wash_Operation(wash_Operation),
    .rinse_Operation(rinse_Operation), .spin_Operation(spin_Operation),
    .lid(lid), .cancel(cancel),
    .fill_Water(fill_Water), .heat_Water(heat_Water), .wash(wash),
    .plant_Error(plant_Error), .busy(busy), .phase(phase)
  );

  function automatic int outs();
    return int'({24'd0, fill_Water, heat_Water, wash, plant_Error, busy, phase});
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return fill_Water;
      1:       return heat_Water;
      default: return wash;
    endcase
  endfunction

  task automatic push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_for(input int sel, output int cnt);
    cnt = 0;
    repeat (40) begin
      step();
      cnt++;
      if (sig(sel)) return;
    end
    cnt = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    push("reset_outs", 0); check(outs());
    #11;
    reset = 1'b0;

    water_Intake = 1'b1;
    step();
    push("fill_entry", O_BUSY); check(outs());
    wait_for(0, n);
    push("fill_latency", 4); check(n);
    push("heat_busy", O_FILL | O_BUSY); check(outs());
    wait_for(1, n);
    push("heat_latency", 3); check(n);
    push("armed_outs", O_FILL | O_HEAT); check(outs());
    water_Intake = 1'b0;

    wash_Operation = 1'b1;
    step();
    push("wash_run", O_FILL | O_HEAT | O_BUSY | 2); check(outs());
    wait_for(2, n);
    push("wash_latency", 5); check(n);
    push("wash_pulse", O_FILL | O_HEAT | O_WASH | 2); check(outs());
    step();
    push("wash_pulse_end", O_FILL | O_HEAT | 2); check(outs());
    wash_Operation = 1'b0;
    step();
    push("wash_rearm", O_FILL | O_HEAT); check(outs());

    soak_Operation = 1'b1;
    step();
    repeat (4) step();
    lid = 1'b1;
    repeat (3) step();
    push("lid_frozen", O_FILL | O_HEAT | O_BUSY | 1); check(outs());
    lid = 1'b0;
    lid_steps = 7;
    wait_for(2, n);
    push("lid_delay", 13); check((n < 0) ? -1 : lid_steps + n);
    soak_Operation = 1'b0;
    step();
    push("soak_rearm", O_FILL | O_HEAT); check(outs());

    rinse_Operation = 1'b1;
    step();
    step();
    rinse_Operation = 1'b0;
    step();
    push("drop_abort", O_FILL | O_HEAT); check(outs());
    repeat (4) step();
    push("drop_no_pulse", O_FILL | O_HEAT); check(outs());

    soak_Operation = 1'b1;
    rinse_Operation = 1'b1;
    step();
    push("halt_entry", O_ERR); check(outs());
    soak_Operation = 1'b0;
    rinse_Operation = 1'b0;
    repeat (3) step();
    push("halt_sticky", O_ERR); check(outs());
    cancel = 1'b1;
    step();
    push("halt_cancel", 0); check(outs());
    cancel = 1'b0;

    water_Intake = 1'b1;
    step();
    wait_for(0, n);
    push("refill_latency", 4); check(n);
    wait_for(1, n);
    push("reheat_latency", 3); check(n);
    water_Intake = 1'b0;

    spin_Operation = 1'b1;
    step();
    push("spin_run", O_FILL | O_HEAT | O_BUSY | 4); check(outs());
    wait_for(2, n);
    push("spin_latency", 5); check(n);
    push("spin_pulse", O_FILL | O_HEAT | O_WASH | 4); check(outs());
    spin_Operation = 1'b0;
    step();
    push("spin_to_idle", 0); check(outs());
    step();
    push("idle_hold", 0); check(outs());

    water_Intake = 1'b1;
    step();
    wait_for(0, n);
    push("fill_before_reset", 4); check(n);
    step();
    #3;
    reset = 1'b1;
    #1;
    push("async_reset", 0); check(outs());
    water_Intake = 1'b0;
    #2;
    reset = 1'b0;
    step();
    push("post_reset_idle", 0); check(outs());
    water_Intake = 1'b1;
    step();
    push("first_edge_fill", O_BUSY); check(outs());

    wait_for(0, n);
    push("fill_again", 4); check(n);
    wait_for(1, n);
    push("heat_again", 3); check(n);
    water_Intake = 1'b0;
    wash_Operation = 1'b1;
    step();
    repeat (4) step();
    cancel = 1'b1;
    step();
    push("cancel_beats_expiry", 0); check(outs());
    cancel = 1'b0;
    wash_Operation = 1'b0;
    step();
    push("cancel_idle", 0); check(outs());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
